m_ext_div_issuer: RTL and testbench

// - Execute-stage initiator for the multi-cycle M-extension divider.
// - Decodes DIV/DIVU/REM/REMU from funct3 and holds operands/divsel stable for the divider.
// - Stalls the pipeline until the divider raises ready, then returns the result
//   as a 1-cycle writeback pulse.
// - Drains the divider back to idle after every op and after every flush.

---
 rtl/m_ext_div_issuer.sv | 135 +++++++++++++
 tb/tb_m_ext_div_issuer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ext_div_issuer.sv
// Execute-stage issuer for the multi-cycle M-extension divider: decode, operand hold, stall and writeback.
// Optional DIV_ZERO_FASTPATH_EN: divide-by-zero completes next cycle without launching the divider.
module m_ext_div_issuer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_timeout,
    output logic [2:0]  div_divsel,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_ready,
    input  logic [31:0] div_res
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]      state_reg;
    logic [31:0]     a_reg;
    logic [31:0]     b_reg;
    logic [4:0]      rd_reg;
    logic [2:0]      divsel_reg;
    logic [WD_W-1:0] wdog_reg;
    logic            wb_valid_reg;
    logic [31:0]     wb_data_reg;
    logic [4:0]      wb_rd_reg;
    logic            err_reg;

    logic        is_div;
    logic        accept;
    logic        zero_fast;
    logic [31:0] fast_res;
    logic [2:0]  divsel_map;

    always_comb begin
        divsel_map = 3'b100;
        case (ex_funct3[1:0])
            2'b00:   divsel_map = 3'b001;
            2'b01:   divsel_map = 3'b010;
            2'b10:   divsel_map = 3'b011;
            default: divsel_map = 3'b100;
        endcase
    end

    assign is_div = ex_valid & ex_funct3[2];
    // The op that just completed is still sitting in EX while wb_valid is high; never re-accept it.
    assign accept = (state_reg == S_IDLE) & is_div & ~flush & ~wb_valid_reg;
    assign stall  = is_div & ~wb_valid_reg & ((state_reg != S_IDLE) | accept);

`ifdef DIV_ZERO_FASTPATH_EN
    assign zero_fast = accept & (ex_rs2 == 32'd0);
    assign fast_res  = ex_funct3[1] ? ex_rs1 : 32'hFFFF_FFFF;
`else
    assign zero_fast = 1'b0;
    assign fast_res  = 32'd0;
`endif

    assign div_divsel  = (state_reg == S_BUSY) ? divsel_reg : 3'b000;
    assign div_a       = a_reg;
    assign div_b       = b_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_data     = wb_data_reg;
    assign wb_rd       = wb_rd_reg;
    assign err_timeout = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            a_reg        <= 32'd0;
            b_reg        <= 32'd0;
            rd_reg       <= 5'd0;
            divsel_reg   <= 3'd0;
            wdog_reg     <= '0;
            wb_valid_reg <= 1'b0;
            wb_data_reg  <= 32'd0;
            wb_rd_reg    <= 5'd0;
            err_reg      <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        a_reg      <= ex_rs1;
                        b_reg      <= ex_rs2;
                        rd_reg     <= ex_rd;
                        divsel_reg <= divsel_map;
                        wdog_reg   <= '0;
                        if (zero_fast) begin
                            wb_valid_reg <= 1'b1;
                            wb_data_reg  <= fast_res;
                            wb_rd_reg    <= ex_rd;
                        end else begin
                            state_reg <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    // Flush beats a simultaneous ready; ready beats the watchdog.
                    if (flush) begin
                        state_reg <= S_DRAIN;
                    end else if (div_ready) begin
                        wb_valid_reg <= 1'b1;
                        wb_data_reg  <= div_res;
                        wb_rd_reg    <= rd_reg;
                        state_reg    <= S_DRAIN;
                    end else if (wdog_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        err_reg   <= 1'b1;
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!div_ready) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_ext_div_issuer.sv
// Directed self-checking bench for m_ext_div_issuer with a behavioural 33-edge divider model.
module tb_m_ext_div_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_timeout;
    logic [2:0]  div_divsel;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_ready;
    logic [31:0] div_res;

    int checks = 0;
    int errors = 0;
    logic stub = 1'b0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int Z_LAT = 1;
`else
    localparam int Z_LAT = 34;
`endif

    always #5 clk = ~clk;

    m_ext_div_issuer #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_timeout(err_timeout), .div_divsel(div_divsel), .div_a(div_a),
        .div_b(div_b), .div_ready(div_ready), .div_res(div_res)
    );

    // Reference divider with RISC-V corner-case semantics
    function automatic logic [31:0] ref_div(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (sel)
            3'b001:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            3'b010:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b011:  return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    logic [5:0] dcnt;
    logic [1:0] rhold;
    logic [31:0] dres;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt  <= 6'd0;
            rhold <= 2'd0;
            dres  <= 32'd0;
        end else begin
            if (rhold != 0) rhold <= rhold - 2'd1;
            if (div_divsel != 3'b000 && !stub) begin
                dcnt <= dcnt + 6'd1;
                if (dcnt == 6'd31) begin
                    rhold <= 2'd2;
                    dres  <= ref_div(div_divsel, div_a, div_b);
                end
            end else begin
                dcnt <= 6'd0;
            end
        end
    end

    assign div_ready = (rhold != 2'd0);
    assign div_res   = dres;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [2:0] exp_sel,
                          input logic [31:0] exp_data, input int exp_lat);
        int n;
        bit seen;
        @(negedge clk);
        ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
        #1;
        check_eq({tag, "_stall_t0"}, 32'(stall), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 1) check_eq({tag, "_divsel_t1"}, 32'(div_divsel), (exp_lat > 1) ? 32'(exp_sel) : 32'd0);
            if (wb_valid) seen = 1'b1;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_data"}, wb_data, exp_data);
        check_eq({tag, "_rd"}, 32'(wb_rd), 32'(rd));
        check_eq({tag, "_stall_wb"}, 32'(stall), 32'd0);
        $display("op %s a=0x%08h b=0x%08h data=0x%08h rd=%0d latency=%0d", tag, a, b, wb_data, wb_rd, n);
        ex_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int m;
        int wb1;
        int wb2;
        int first;
        int errs;
        int wbs;
        rst = 1'b1; ex_valid = 1'b0; ex_funct3 = 3'd0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_divsel", 32'(div_divsel), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;

        run_op("div_m20_3",   3'b100, 32'hFFFF_FFEC, 32'd3,          5'd10, 3'b001, 32'hFFFF_FFFA, 34);
        run_op("remu_ff_16",  3'b111, 32'hFFFF_FFFF, 32'd16,         5'd11, 3'b100, 32'h0000_000F, 34);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,          5'd12, 3'b011, 32'hFFFF_FFFF, 34);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  5'd13, 3'b001, 32'h8000_0000, 34);
        run_op("div_5_0",     3'b100, 32'd5,         32'd0,          5'd14, 3'b001, 32'hFFFF_FFFF, Z_LAT);
        run_op("rem_5_0",     3'b110, 32'd5,         32'd0,          5'd15, 3'b011, 32'h0000_0005, Z_LAT);
        run_op("rem_x0",      3'b110, 32'd100,       32'd7,          5'd0,  3'b011, 32'h0000_0002, 34);

        // flush coinciding with accept, plus a non-div funct3
        @(negedge clk);
        ex_valid = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd1; flush = 1'b1;
        #1;
        check_eq("flush_accept_stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0; ex_funct3 = 3'b000;
        #1;
        check_eq("flush_accept_divsel", 32'(div_divsel), 32'd0);
        check_eq("nondiv_stall", 32'(stall), 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        check_eq("nondiv_divsel", 32'(div_divsel), 32'd0);
        $display("op flush_on_accept and non-div funct3 checked");

        // flush in T10 of DIVU 100/7
        @(negedge clk);
        ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd2;
        wbs = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            #1;
            if (wb_valid) wbs++;
            if (n == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        #1;
        if (wb_valid) wbs++;
        check_eq("flush_divsel_t11", 32'(div_divsel), 32'd0);
        check_eq("flush_no_wb", 32'(wbs), 32'd0);
        $display("op flush_t10 divsel=%0d wb_count=%0d", div_divsel, wbs);
        run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 5'd2, 3'b010, 32'h0000_000E, 34);

        // back-to-back DIV then REM held in EX
        @(negedge clk);
        ex_valid = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd3;
        m = 0; wb1 = -1; wb2 = -1;
        while (m < 120 && wb2 < 0) begin
            @(negedge clk);
            #1;
            m++;
            if (wb_valid) begin
                if (wb1 < 0) begin
                    wb1 = m;
                    check_eq("b2b_first_data", wb_data, 32'd14);
                end else begin
                    wb2 = m;
                    check_eq("b2b_second_data", wb_data, 32'd2);
                    check_eq("b2b_second_rd", 32'(wb_rd), 32'd5);
                end
            end
            if (m == 35) begin
                ex_funct3 = 3'b110; ex_rd = 5'd5;
                #1;
                check_eq("b2b_drain_stall", 32'(stall), 32'd1);
            end
            if (m == 37) check_eq("b2b_second_divsel", 32'(div_divsel), 32'd3);
        end
        ex_valid = 1'b0;
        check_eq("b2b_first_cycle", 32'(wb1), 32'd34);
        check_eq("b2b_second_cycle", 32'(wb2), 32'd70);
        $display("op back_to_back wb1=T%0d wb2=T%0d", wb1, wb2);
        repeat (3) @(negedge clk);

        // watchdog with a divider that never answers
        stub = 1'b1;
        @(negedge clk);
        ex_valid = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd9; ex_rs2 = 32'd3; ex_rd = 5'd4;
        first = -1; errs = 0; wbs = 0;
        for (int n = 1; n <= 75; n++) begin
            @(negedge clk);
            #1;
            if (wb_valid) wbs++;
            if (err_timeout) begin
                errs++;
                if (first < 0) begin
                    first = n;
                    ex_valid = 1'b0;
                end
            end
        end
        check_eq("timeout_cycle", 32'(first), 32'd65);
        check_eq("timeout_pulses", 32'(errs), 32'd1);
        check_eq("timeout_no_wb", 32'(wbs), 32'd0);
        $display("op timeout err_at=T%0d pulses=%0d wb_count=%0d", first, errs, wbs);
        stub = 1'b0;
        run_op("div_after_timeout", 3'b100, 32'd100, 32'd7, 5'd6, 3'b001, 32'h0000_000E, 34);

        // asynchronous reset in the middle of BUSY
        @(negedge clk);
        ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd8;
        repeat (10) @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_divsel", 32'(div_divsel), 32'd0);
        check_eq("midrst_div_a", div_a, 32'd0);
        check_eq("midrst_wb_data", wb_data, 32'd0);
        check_eq("midrst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("midrst_stall", 32'(stall), 32'd0);
        $display("op mid_busy_reset divsel=%0d wb_data=0x%08h", div_divsel, wb_data);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 5'd8, 3'b010, 32'h0000_000E, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
